// File: rtl/sonic_array.sv
// Round-robin driver for NCH HC-SR04-style ultrasonic rangers: one trigger at a time,
// echo timed in microseconds, converted to centimetres, with per-channel presence hysteresis.
module sonic_array #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int NCH        = 2,
  parameter int DW         = 16,
  parameter int TRIG_US    = 10,
  parameter int SLOT_MS    = 40,
  parameter int TIMEOUT_US = 30000,
  parameter int CM_DIV     = 58,
  parameter int NEAR_CM    = 80,
  parameter int HYST_CM    = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NCH-1:0]    echo,
  output logic [NCH-1:0]    trig,
  output logic [NCH*DW-1:0] distance,
  output logic [NCH-1:0]    dist_valid,
  output logic [NCH-1:0]    timeout,
  output logic [NCH-1:0]    near,
  output logic [2:0]        active_ch
);

  localparam int DIV    = CLK_HZ / 1_000_000;
  localparam int PW     = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int CW     = $clog2(TIMEOUT_US + 1);
  localparam int SLOT_T = SLOT_MS * 1000;
  localparam int SW     = $clog2(SLOT_T + 1);
  localparam int CHW    = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [2:0] {S_IDLE, S_TRIG, S_WAIT, S_MEAS, S_DONE, S_TOUT, S_GAP} state_t;

  state_t             state_q, state_d;
  logic [PW-1:0]      pre_q;
  logic               tick;
  logic [NCH-1:0]     echo_m_q, echo_s_q, echo_p_q;
  logic [CHW-1:0]     ch_q, ch_d;
  logic [CW-1:0]      tmr_q, tmr_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [SW-1:0]      slot_q, slot_d;
  logic [NCH-1:0]     trig_q, trig_d;
  logic [NCH*DW-1:0]  dist_q, dist_d;
  logic [NCH-1:0]     vld_q, vld_d;
  logic [NCH-1:0]     tout_q, tout_d;
  logic [NCH-1:0]     near_q, near_d;
  logic               echo_cur, rise, do_done, do_tout;
  logic [DW-1:0]      dist_new;

  // Floor division to centimetres, clamped to the all-ones code.
  function automatic logic [DW-1:0] sat_cm(input logic [CW-1:0] us);
    logic [CW-1:0] q;
    q = us / CW'(CM_DIV);
    if ((q >> DW) != '0) return '1;
    return DW'(q);
  endfunction

  assign tick     = (pre_q == PW'(DIV - 1));
  assign echo_cur = echo_s_q[ch_q];
  assign rise     = echo_cur & ~echo_p_q[ch_q];
  assign dist_new = sat_cm(cnt_q);

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    tmr_d   = tmr_q;
    cnt_d   = cnt_q;
    slot_d  = slot_q;
    dist_d  = dist_q;
    vld_d   = '0;
    tout_d  = '0;
    near_d  = near_q;
    do_done = 1'b0;
    do_tout = 1'b0;
    if (state_q != S_IDLE && tick && slot_q != SW'(SLOT_T)) slot_d = slot_q + 1'b1;
    case (state_q)
      S_IDLE: if (tick) begin
        state_d = S_TRIG;
        tmr_d   = '0;
        slot_d  = '0;
      end
      S_TRIG: if (tick) begin
        if (tmr_q == CW'(TRIG_US - 1)) begin
          state_d = S_WAIT;
          tmr_d   = '0;
        end else tmr_d = tmr_q + 1'b1;
      end
      S_WAIT: begin
        if (rise) begin
          // the rising-edge cycle itself is the first high tick
          state_d = S_MEAS;
          cnt_d   = {{(CW-1){1'b0}}, tick};
        end else if (tick) begin
          if (tmr_q == CW'(TIMEOUT_US - 1)) begin
            state_d = S_TOUT;
            do_tout = 1'b1;
          end else tmr_d = tmr_q + 1'b1;
        end
      end
      S_MEAS: begin
        if (!echo_cur) begin
          state_d = S_DONE;
          do_done = 1'b1;
        end else if (tick) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_d == CW'(TIMEOUT_US)) begin
            state_d = S_TOUT;
            do_tout = 1'b1;
          end
        end
      end
      S_DONE, S_TOUT: state_d = S_GAP;
      S_GAP: begin
        // leave one tick early so IDLE's tick lands exactly on the slot boundary
        if (slot_d >= SW'(SLOT_T - 1)) begin
          state_d = S_IDLE;
          ch_d    = (ch_q == CHW'(NCH - 1)) ? '0 : ch_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (do_done) begin
      dist_d[int'(ch_q)*DW +: DW] = dist_new;
      vld_d[ch_q] = 1'b1;
      if (dist_new < DW'(NEAR_CM)) near_d[ch_q] = 1'b1;
      else if (dist_new >= DW'(NEAR_CM + HYST_CM)) near_d[ch_q] = 1'b0;
    end
    if (do_tout) begin
      dist_d[int'(ch_q)*DW +: DW] = '1;
      tout_d[ch_q] = 1'b1;
      near_d[ch_q] = 1'b0;
    end
    trig_d = (state_d == S_TRIG) ? (NCH'(1) << ch_d) : '0;
  end

  // stage boundary: every register, outputs included, clears on reset
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pre_q    <= '0;
      echo_m_q <= '0;
      echo_s_q <= '0;
      echo_p_q <= '0;
      state_q  <= S_IDLE;
      ch_q     <= '0;
      tmr_q    <= '0;
      cnt_q    <= '0;
      slot_q   <= '0;
      trig_q   <= '0;
      dist_q   <= '0;
      vld_q    <= '0;
      tout_q   <= '0;
      near_q   <= '0;
    end else begin
      pre_q    <= tick ? '0 : pre_q + 1'b1;
      echo_m_q <= echo;
      echo_s_q <= echo_m_q;
      echo_p_q <= echo_s_q;
      state_q  <= state_d;
      ch_q     <= ch_d;
      tmr_q    <= tmr_d;
      cnt_q    <= cnt_d;
      slot_q   <= slot_d;
      trig_q   <= trig_d;
      dist_q   <= dist_d;
      vld_q    <= vld_d;
      tout_q   <= tout_d;
      near_q   <= near_d;
    end
  end

  assign trig       = trig_q;
  assign distance   = dist_q;
  assign dist_valid = vld_q;
  assign timeout    = tout_q;
  assign near       = near_q;
  assign active_ch  = 3'(ch_q);

endmodule

// File: tb/tb_sonic_array.sv
// Directed bench for sonic_array, scaled to a 1 MHz clock (one tick per cycle), 5 ms slots
// and a 4950 us timeout so a dozen slots fit in a short run.
module tb_sonic_array;
  localparam int NCH        = 2;
  localparam int DW         = 16;
  localparam int TRIG_US    = 10;
  localparam int SLOT_MS    = 5;
  localparam int TIMEOUT_US = 4950;
  localparam int SLOT_T     = SLOT_MS * 1000;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NCH-1:0]    echo = '0;
  logic [NCH-1:0]    trig, dist_valid, timeout, near;
  logic [NCH*DW-1:0] distance;
  logic [2:0]        active_ch;

  int unsigned cyc = 0;
  int n_tests = 0;
  int n_fail = 0;
  int vld0 = 0;
  int vld1 = 0;
  int multi = 0;

  sonic_array #(
    .CLK_HZ(1_000_000), .NCH(NCH), .DW(DW), .TRIG_US(TRIG_US), .SLOT_MS(SLOT_MS),
    .TIMEOUT_US(TIMEOUT_US), .CM_DIV(58), .NEAR_CM(80), .HYST_CM(5)
  ) dut (
    .clock(clk), .reset(rst), .echo(echo), .trig(trig), .distance(distance),
    .dist_valid(dist_valid), .timeout(timeout), .near(near), .active_ch(active_ch)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (dist_valid[0]) vld0 <= vld0 + 1;
    if (dist_valid[1]) vld1 <= vld1 + 1;
    if ($countones(trig) > 1) multi <= multi + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_rise(input int k, output int unsigned t);
    int n;
    n = 0;
    while (trig[k] !== 1'b1 && n < SLOT_T + 1000) begin @(negedge clk); n++; end
    chk($sformatf("trig%0d_rise", k), 32'(trig[k]), 32'd1);
    t = cyc;
  endtask

  task automatic wait_fall(input int k, output int unsigned t);
    int n;
    n = 0;
    while (trig[k] !== 1'b0 && n < 100) begin @(negedge clk); n++; end
    chk($sformatf("trig%0d_fall", k), 32'(trig[k]), 32'd0);
    t = cyc;
  endtask

  task automatic wait_tout(input int k, output int unsigned t);
    int n;
    n = 0;
    while (timeout[k] !== 1'b1 && n < TIMEOUT_US + 100) begin @(negedge clk); n++; end
    chk($sformatf("timeout%0d_seen", k), 32'(timeout[k]), 32'd1);
    t = cyc;
  endtask

  // ch0 measurement: echo high for n us, 20 us after trig falls; checks 3-clock latency
  task automatic meas(input int unsigned tr, input int n, input int exp_cm,
                      input logic exp_near, input string tag);
    int unsigned tf;
    wait_fall(0, tf);
    chk({tag, "_trig_w"}, 32'(tf - tr), 32'(TRIG_US));
    repeat (20) @(negedge clk);
    echo[0] = 1'b1;
    repeat (n) @(negedge clk);
    echo[0] = 1'b0;
    repeat (2) @(negedge clk);
    chk({tag, "_lat2"}, 32'(dist_valid), 32'd0);
    @(negedge clk);
    chk({tag, "_valid"}, 32'(dist_valid), 32'b01);
    chk({tag, "_dist"}, 32'(distance[15:0]), 32'(exp_cm));
    chk({tag, "_near"}, 32'(near[0]), 32'(exp_near));
    @(negedge clk);
    chk({tag, "_pulse"}, 32'(dist_valid), 32'd0);
  endtask

  initial begin
    int unsigned t0, t, tf, tt;
    repeat (3) @(negedge clk);
    chk("rst_trig", 32'(trig), 32'd0);
    chk("rst_dist", 32'(distance), 32'd0);
    chk("rst_vld", 32'(dist_valid), 32'd0);
    chk("rst_tout", 32'(timeout), 32'd0);
    chk("rst_near", 32'(near), 32'd0);
    chk("rst_ch", 32'(active_ch), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("first_tick_trig", 32'(trig), 32'b01);
    t0 = cyc;
    chk("ch0_active", 32'(active_ch), 32'd0);

    // 1160 us -> 20 cm, near set
    meas(t0, 1160, 20, 1'b1, "t1");

    // ch1 slot: no echo on ch1; a pulse on idle ch0 must be ignored
    wait_rise(1, t);
    chk("ch1_slot_start", 32'(t - t0), 32'(SLOT_T));
    chk("ch1_active", 32'(active_ch), 32'd1);
    wait_fall(1, tf);
    echo[0] = 1'b1;
    repeat (200) @(negedge clk);
    echo[0] = 1'b0;
    wait_tout(1, tt);
    chk("ch1_tout_time", 32'(tt - tf), 32'(TIMEOUT_US));
    chk("ch1_dist_sat", 32'(distance[31:16]), 32'hFFFF);
    chk("ch1_near", 32'(near[1]), 32'd0);
    chk("ch1_no_valid", 32'(vld1), 32'd0);
    chk("ch0_one_valid", 32'(vld0), 32'd1);

    // ch0 with no echo: timeout, saturated distance, near cleared
    wait_rise(0, t);
    chk("ch0_rerise", 32'(t - t0), 32'(2 * SLOT_T));
    wait_fall(0, tf);
    wait_tout(0, tt);
    chk("t3_tout_time", 32'(tt - tf), 32'(TIMEOUT_US));
    chk("t3_tout_only0", 32'(timeout), 32'b01);
    chk("t3_dist", 32'(distance[15:0]), 32'hFFFF);
    chk("t3_near", 32'(near[0]), 32'd0);
    chk("t3_no_valid", 32'(vld0), 32'd1);

    // hysteresis: 79 sets, 82 holds, 85 clears
    wait_rise(1, t);
    wait_rise(0, t);
    meas(t, 4582, 79, 1'b1, "t2a");
    wait_rise(1, t);
    wait_rise(0, t);
    meas(t, 4756, 82, 1'b1, "t2b");
    wait_rise(1, t);
    wait_rise(0, t);
    meas(t, 4930, 85, 1'b0, "t2c");

    // echo stuck high before the slot opens: no rise, timeout, no valid
    wait_rise(1, t);
    @(negedge clk);
    echo[0] = 1'b1;
    wait_rise(0, t);
    wait_fall(0, tf);
    wait_tout(0, tt);
    chk("t5_tout_time", 32'(tt - tf), 32'(TIMEOUT_US));
    chk("t5_dist", 32'(distance[15:0]), 32'hFFFF);
    chk("t5_no_valid", 32'(vld0), 32'd4);
    echo[0] = 1'b0;

    // reset in the middle of a measurement
    wait_rise(1, t);
    wait_rise(0, t);
    wait_fall(0, tf);
    repeat (20) @(negedge clk);
    echo[0] = 1'b1;
    repeat (100) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("t6_trig", 32'(trig), 32'd0);
    chk("t6_dist", 32'(distance), 32'd0);
    chk("t6_near", 32'(near), 32'd0);
    chk("t6_ch", 32'(active_ch), 32'd0);
    echo[0] = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("t6_first_tick", 32'(trig), 32'b01);
    t = cyc;
    meas(t, 1160, 20, 1'b1, "t6m");

    chk("trig_exclusive", 32'(multi), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
